// File: rtl/regfile_pkg.sv
// Shared defaults and types for the decode-stage multi-port register file.
package regfile_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int DEPTH_DEF    = 32;
  localparam int ZERO_REG_DEF = 0;

  typedef logic [DATA_W_DEF-1:0]         reg_data_t;
  typedef logic [$clog2(DEPTH_DEF)-1:0]  reg_addr_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/scoreboard bus of the multi-port register file; master drives requests, slave is the regfile.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*AW-1:0]     ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic [NUM_RD-1:0]        rd_valid;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     we;
  logic [AW-1:0]            wa;
  logic [DATA_W-1:0]        wd;
  logic                     busy_set;
  logic [AW-1:0]            busy_addr;

  modport master (
    output re, ra, we, wa, wd, busy_set, busy_addr,
    input  rd, rd_valid, rd_busy
  );

  modport slave (
    input  re, ra, we, wa, wd, busy_set, busy_addr,
    output rd, rd_valid, rd_busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy flags: set marks an in-flight producer, a write clears it, set wins on a tie.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_en,
  input  logic [$clog2(DEPTH)-1:0] set_addr,
  input  logic                     clr_en,
  input  logic [$clog2(DEPTH)-1:0] clr_addr,
  output logic [DEPTH-1:0]         busy
);
  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

  logic set_ok;

  assign set_ok = set_en && (set_addr != ZERO_A);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (set_ok && (set_addr == AW'(i)))
          busy[i] <= 1'b1;
        else if (clr_en && (clr_addr == AW'(i)))
          busy[i] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// NUM_RD-read / 1-write register file with registered reads, hardwired zero register and busy scoreboard.
// Build option REGFILE_MP_BYPASS_EN forwards a same-edge write to the reads of that address.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_mp_if.slave   bus
);
  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DEPTH-1:0]         busy;
  logic                     wr_ok;
  logic [NUM_RD*DATA_W-1:0] rd_p1, rd_nxt;
  logic [NUM_RD-1:0]        vld_p1;
  logic [NUM_RD-1:0]        busy_p1, busy_nxt;

  assign wr_ok = bus.we && (bus.wa != ZERO_A);

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (bus.busy_set),
    .set_addr (bus.busy_addr),
    .clr_en   (wr_ok),
    .clr_addr (bus.wa),
    .busy     (busy)
  );

  // Read select: disabled ports keep their last data and busy flag
  always_comb begin
    rd_nxt   = rd_p1;
    busy_nxt = busy_p1;
    for (int i = 0; i < NUM_RD; i++) begin
      if (bus.re[i]) begin
        if (bus.ra[i*AW +: AW] == ZERO_A) begin
          rd_nxt[i*DATA_W +: DATA_W] = '0;
          busy_nxt[i]                = 1'b0;
`ifdef REGFILE_MP_BYPASS_EN
        end else if (wr_ok && (bus.ra[i*AW +: AW] == bus.wa)) begin
          // Forwarded value; the write has cleared busy, a same-edge set is not yet visible
          rd_nxt[i*DATA_W +: DATA_W] = bus.wd;
          busy_nxt[i]                = 1'b0;
`endif
        end else begin
          rd_nxt[i*DATA_W +: DATA_W] = mem[bus.ra[i*AW +: AW]];
          busy_nxt[i]                = busy[bus.ra[i*AW +: AW]];
        end
      end
    end
  end

  // Stage p1: storage update and registered read outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
      rd_p1   <= '0;
      vld_p1  <= '0;
      busy_p1 <= '0;
    end else begin
      if (wr_ok) mem[bus.wa] <= bus.wd;
      rd_p1   <= rd_nxt;
      vld_p1  <= bus.re;
      busy_p1 <= busy_nxt;
    end
  end

  assign bus.rd       = rd_p1;
  assign bus.rd_valid = vld_p1;
  assign bus.rd_busy  = busy_p1;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (64-bit, 32 entries, 2 read ports).
module tb_regfile_mp;
  import regfile_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  regfile_mp_if #(.DATA_W(64), .DEPTH(32), .NUM_RD(2)) bus ();

  regfile_mp #(.DATA_W(64), .DEPTH(32), .NUM_RD(2), .ZERO_REG(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.re        = 2'b00;
    bus.we        = 1'b0;
    bus.busy_set  = 1'b0;
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] en);
    bus.ra = {a1, a0};
    bus.re = en;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    bus.re       = '0;
    bus.ra       = '0;
    bus.we       = 1'b0;
    bus.wa       = '0;
    bus.wd       = '0;
    bus.busy_set = 1'b0;
    bus.busy_addr = '0;
    tick();
    tick();
    chk("reset_rd",    bus.rd[127:0] == 128'd0, 64'd1);
    chk("reset_valid", 64'(bus.rd_valid), 64'd0);
    chk("reset_busy",  64'(bus.rd_busy), 64'd0);
    rst_n = 1'b1;

    // Reset clears a previously written register
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 64'hDEAD;
    tick();
    idle(); rd2(5'd5, 5'd0, 2'b01);
    tick();
    chk("pre_reset_rd5", bus.rd[63:0], 64'hDEAD);
    rst_n = 1'b0;
    tick();
    chk("in_reset_valid", 64'(bus.rd_valid), 64'd0);
    chk("in_reset_rd",    bus.rd[63:0], 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_rd5",   bus.rd[63:0], 64'd0);
    chk("post_reset_busy",  64'(bus.rd_busy), 64'd0);
    chk("post_reset_valid", 64'(bus.rd_valid), 64'd1);

    // Basic write then dual-port read
    idle(); bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 64'h1234_5678_9ABC_DEF0;
    tick();
    idle(); rd2(5'd3, 5'd0, 2'b11);
    tick();
    chk("basic_rd0",   bus.rd[63:0],   64'h1234_5678_9ABC_DEF0);
    chk("basic_rd1",   bus.rd[127:64], 64'd0);
    chk("basic_valid", 64'(bus.rd_valid), 64'd3);

    // Zero register ignores writes and busy_set
    idle(); bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.busy_set = 1'b1; bus.busy_addr = 5'd0;
    tick();
    idle(); rd2(5'd0, 5'd0, 2'b01);
    tick();
    chk("zero_rd",   bus.rd[63:0], 64'd0);
    chk("zero_busy", 64'(bus.rd_busy[0]), 64'd0);

    // Scoreboard set, seen on both ports with equal addresses
    idle(); bus.busy_set = 1'b1; bus.busy_addr = 5'd7;
    tick();
    idle(); rd2(5'd7, 5'd7, 2'b11);
    tick();
    chk("sb_busy_both", 64'(bus.rd_busy), 64'd3);
    chk("sb_same_data", bus.rd[63:0] == bus.rd[127:64], 64'd1);
    idle(); bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 64'h42;
    tick();
    idle(); rd2(5'd7, 5'd0, 2'b01);
    tick();
    chk("sb_clr_rd",   bus.rd[63:0], 64'h42);
    chk("sb_clr_busy", 64'(bus.rd_busy[0]), 64'd0);
    idle(); bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 64'h43;
    bus.busy_set = 1'b1; bus.busy_addr = 5'd7;
    tick();
    idle(); rd2(5'd7, 5'd0, 2'b01);
    tick();
    chk("sb_setwins_rd",   bus.rd[63:0], 64'h43);
    chk("sb_setwins_busy", 64'(bus.rd_busy[0]), 64'd1);

    // Same-edge write/read hazard on reg9
    idle(); bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 64'h11;
    bus.busy_set = 1'b1; bus.busy_addr = 5'd9;
    tick();
    idle(); bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 64'h22; rd2(5'd9, 5'd0, 2'b01);
    tick();
`ifdef REGFILE_MP_BYPASS_EN
    chk("hazard_rd",   bus.rd[63:0], 64'h22);
    chk("hazard_busy", 64'(bus.rd_busy[0]), 64'd0);
`else
    chk("hazard_rd",   bus.rd[63:0], 64'h11);
    chk("hazard_busy", 64'(bus.rd_busy[0]), 64'd1);
`endif
    idle(); rd2(5'd9, 5'd7, 2'b11);
    tick();
    chk("hazard_next_rd",   bus.rd[63:0], 64'h22);
    chk("hazard_next_busy", 64'(bus.rd_busy), 64'd2);

    // Same-edge write + busy_set + read on reg10: the set is not visible in either mode
    idle(); bus.we = 1'b1; bus.wa = 5'd10; bus.wd = 64'hA0;
    bus.busy_set = 1'b1; bus.busy_addr = 5'd10; rd2(5'd10, 5'd0, 2'b01);
    tick();
    chk("hazard_set_busy", 64'(bus.rd_busy[0]), 64'd0);
    idle(); rd2(5'd10, 5'd9, 2'b11);
    tick();
    chk("after_set_busy", 64'(bus.rd_busy), 64'd1);
    chk("after_set_rd",   bus.rd[63:0], 64'hA0);

    // Hold: outputs keep their values with re=0
    idle();
    tick();
    chk("hold_valid", 64'(bus.rd_valid), 64'd0);
    chk("hold_rd0",   bus.rd[63:0],   64'hA0);
    chk("hold_rd1",   bus.rd[127:64], 64'h22);
    chk("hold_busy",  64'(bus.rd_busy), 64'd1);

    // Mid-operation reset overrides write and busy_set
    bus.we = 1'b1; bus.wa = 5'd12; bus.wd = 64'h55;
    bus.busy_set = 1'b1; bus.busy_addr = 5'd12;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle(); rd2(5'd12, 5'd7, 2'b11);
    tick();
    chk("midrst_rd12",  bus.rd[63:0],   64'd0);
    chk("midrst_rd7",   bus.rd[127:64], 64'd0);
    chk("midrst_busy",  64'(bus.rd_busy), 64'd0);
    idle(); rd2(5'd3, 5'd10, 2'b11);
    tick();
    chk("midrst_rd3",   bus.rd[63:0],   64'd0);
    chk("midrst_rd10b", 64'(bus.rd_busy[1]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
